clock_set_controller: RTL and testbench

- Front-end sequencer for the clock/alarm input router.
- Takes three raw pushbuttons (MODE, ADV, CLR) and produces the 2-bit target selector plus single-cycle increment and clear pulses that feed the router's selector, increment and reset inputs.
- Provides synchronisation, debouncing, target cycling (clock → alarm1 → alarm2 → alarm3), hold-to-auto-repeat on ADV, and an inactivity timeout that returns the selection to the main clock.

---
 rtl/clock_set_pkg.sv | 34 +++
 rtl/button_debounce.sv | 51 +++++
 rtl/clock_set_controller.sv | 146 ++++++++++++++
 tb/tb_clock_set_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_pkg.sv
// ============================================================================
// clock_set_pkg -- shared select encoding and ADV sequencer states
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_set_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_CLOCK  = 2'b00;
    localparam sel_t SEL_ALARM1 = 2'b01;
    localparam sel_t SEL_ALARM2 = 2'b10;
    localparam sel_t SEL_ALARM3 = 2'b11;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_DELAY  = 2'd1,
        A_REPEAT = 2'd2,
        A_HOLD   = 2'd3
    } adv_state_t;

    function automatic sel_t next_sel(input sel_t cur);
        case (cur)
            SEL_CLOCK:  return SEL_ALARM1;
            SEL_ALARM1: return SEL_ALARM2;
            SEL_ALARM2: return SEL_ALARM3;
            default:    return SEL_CLOCK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce -- two-flop synchroniser, stable-count debounce, rise pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_meta;
    logic          sync;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync       <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            rise       <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
            level_d   <= level;
            rise      <= level & ~level_d;
            // Count only an unbroken run of samples disagreeing with the level.
            if (sync == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level      <= ~level;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_set_controller.sv
// ============================================================================
// clock_set_controller -- button front end: target cycling, INC auto-repeat,
// CLR pulse and inactivity return to the main clock.  Rev 1.0
// ============================================================================
`default_nettype none

module clock_set_controller
    import clock_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3,
    parameter int IDLE_TIMEOUT    = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_MODE,
    input  logic       BTN_ADV,
    input  logic       BTN_CLR,
    output logic [1:0] S,
    output logic       INC_OUT,
    output logic       CLR_OUT,
    output logic       EDIT_ACTIVE
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam int IW      = $clog2(IDLE_TIMEOUT + 1);

    logic          mode_level;
    logic          mode_rise;
    logic          adv_level;
    logic          adv_rise;
    logic          clr_level;
    logic          clr_rise;

    logic          mode_win;
    logic          any_rise;
    logic          any_level;
    logic          timeout;
    sel_t          sel_next;

    adv_state_t    adv_state;
    logic [RW-1:0] rep_cnt;
    logic [IW-1:0] idle_cnt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (CLK),
        .rst   (RESET),
        .btn   (BTN_MODE),
        .level (mode_level),
        .rise  (mode_rise)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv_db (
        .clk   (CLK),
        .rst   (RESET),
        .btn   (BTN_ADV),
        .level (adv_level),
        .rise  (adv_rise)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk   (CLK),
        .rst   (RESET),
        .btn   (BTN_CLR),
        .level (clr_level),
        .rise  (clr_rise)
    );

    // CLR outranks MODE, which outranks ADV; a losing pulse is simply dropped.
    always_comb begin
        mode_win  = mode_rise & ~clr_rise;
        any_rise  = mode_rise | adv_rise | clr_rise;
        any_level = mode_level | adv_level | clr_level;
        timeout   = (idle_cnt == IW'(IDLE_TIMEOUT));
        sel_next  = S;
        if (mode_win) begin
            sel_next = next_sel(S);
        end else if (timeout) begin
            sel_next = SEL_CLOCK;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            S           <= SEL_CLOCK;
            EDIT_ACTIVE <= 1'b0;
            CLR_OUT     <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            S           <= sel_next;
            EDIT_ACTIVE <= (sel_next != SEL_CLOCK);
            CLR_OUT     <= clr_rise;
            if (any_rise || any_level || (S == SEL_CLOCK) || timeout) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    // ADV sequencer: a suppressed INC still advances the repeat schedule.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            adv_state <= A_IDLE;
            rep_cnt   <= '0;
            INC_OUT   <= 1'b0;
        end else begin
            INC_OUT <= 1'b0;
            if (mode_win) begin
                adv_state <= A_HOLD;
            end else begin
                case (adv_state)
                    A_IDLE: begin
                        if (adv_rise) begin
                            INC_OUT   <= ~clr_rise;
                            rep_cnt   <= RW'(REPEAT_DELAY);
                            adv_state <= A_DELAY;
                        end
                    end
                    A_DELAY, A_REPEAT: begin
                        if (!adv_level) begin
                            adv_state <= A_IDLE;
                        end else if (rep_cnt <= RW'(1)) begin
                            INC_OUT   <= ~clr_rise;
                            rep_cnt   <= RW'(REPEAT_PERIOD);
                            adv_state <= A_REPEAT;
                        end else begin
                            rep_cnt <= rep_cnt - RW'(1);
                        end
                    end
                    A_HOLD: begin
                        if (!adv_level) begin
                            adv_state <= A_IDLE;
                        end
                    end
                    default: adv_state <= A_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_set_controller.sv
// ============================================================================
// tb_clock_set_controller -- timestamp-based reference model, directed and
// random button stimulus.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_clock_set_controller;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam int IT = 20;
    localparam int HN = 16384;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       b_mode = 1'b0;
    logic       b_adv  = 1'b0;
    logic       b_clr  = 1'b0;
    logic [1:0] s;
    logic       inc;
    logic       clr_o;
    logic       edit;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    clock_set_controller #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .IDLE_TIMEOUT    (IT)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .BTN_MODE    (b_mode),
        .BTN_ADV     (b_adv),
        .BTN_CLR     (b_clr),
        .S           (s),
        .INC_OUT     (inc),
        .CLR_OUT     (clr_o),
        .EDIT_ACTIVE (edit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: buttons 0=MODE 1=ADV 2=CLR, times are edge indices.
    bit hist [3][HN];
    bit lvl [3];
    int last_flip [3];
    int last_up [3];
    int m_s = 0;
    bit m_inc = 0;
    bit m_clr = 0;
    bit adv_active = 0;
    bit adv_hold = 0;
    int next_fire = 0;
    int last_clear = 0;
    bit model_valid = 0;

    function automatic bit raw_at(input int b, input int m);
        if (m < 0) return 1'b0;
        return hist[b][m % HN];
    endfunction

    always @(posedge clk) begin : model
        bit rs [3];
        bit mode_win;
        bit timeout;
        bit any_act;
        bit ok;
        int n;
        n = cyc;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                hist[b][n % HN] = 1'b0;
                if (n >= 1) hist[b][(n - 1) % HN] = 1'b0;
                lvl[b]       = 1'b0;
                last_flip[b] = n;
                last_up[b]   = -100;
            end
            m_s = 0; m_inc = 0; m_clr = 0;
            adv_active = 0; adv_hold = 0; next_fire = 0;
            last_clear = n;
            model_valid = 1;
        end else begin
            // A rise pulse is seen two edges after the edge the level went high.
            for (int b = 0; b < 3; b++) rs[b] = (last_up[b] == n - 2);
            mode_win = rs[0] && !rs[2];
            m_clr = rs[2];
            m_inc = 0;
            if (mode_win) begin
                adv_hold = 1; adv_active = 0;
            end else if (adv_hold) begin
                if (!lvl[1]) adv_hold = 0;
            end else if (adv_active) begin
                if (!lvl[1]) adv_active = 0;
                else if (n == next_fire) begin
                    m_inc = !rs[2];
                    next_fire = n + RP;
                end
            end else if (rs[1]) begin
                m_inc = !rs[2];
                adv_active = 1;
                next_fire = n + RD;
            end
            timeout = (m_s != 0) && (n - 1 - last_clear == IT);
            any_act = rs[0] | rs[1] | rs[2] | lvl[0] | lvl[1] | lvl[2];
            if (any_act || m_s == 0 || timeout) last_clear = n;
            if (mode_win) m_s = (m_s + 1) % 4;
            else if (timeout) m_s = 0;

            hist[0][n % HN] = b_mode;
            hist[1][n % HN] = b_adv;
            hist[2][n % HN] = b_clr;
            // Level flips once DB consecutive synchronised samples disagree.
            for (int b = 0; b < 3; b++) begin
                ok = (n - DB >= last_flip[b]);
                for (int k = 0; k < DB; k++)
                    if (raw_at(b, n - 2 - k) == lvl[b]) ok = 0;
                if (ok) begin
                    lvl[b] = !lvl[b];
                    last_flip[b] = n;
                    if (lvl[b]) last_up[b] = n;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("S",           32'(s),     32'(m_s));
            check("INC_OUT",     32'(inc),   32'(m_inc));
            check("CLR_OUT",     32'(clr_o), 32'(m_clr));
            check("EDIT_ACTIVE", 32'(edit),  32'(m_s != 0));
        end
    end

    task automatic wait_edges(input int k);
        repeat (k) @(negedge clk);
    endtask

    int inc_seen;
    int inc_at [3];

    initial begin
        wait_edges(3);
        check("reset_S",    32'(s),     32'd0);
        check("reset_INC",  32'(inc),   32'd0);
        check("reset_CLR",  32'(clr_o), 32'd0);
        check("reset_EDIT", 32'(edit),  32'd0);
        rst = 1'b0;
        wait_edges(2);

        // MODE: effect exactly 7 edges after the first sampling edge.
        b_mode = 1'b1;
        wait_edges(7);
        check("mode_lat_pre_S", 32'(s), 32'd0);
        wait_edges(1);
        check("mode_lat_S",    32'(s),    32'd1);
        check("mode_lat_EDIT", 32'(edit), 32'd1);
        check("mode_lat_INC",  32'(inc),  32'd0);
        wait_edges(2);
        b_mode = 1'b0;
        wait_edges(8);

        // CLR and MODE together at S=01: only CLR acts.
        b_clr = 1'b1; b_mode = 1'b1;
        wait_edges(7);
        check("clr_pre_CLR", 32'(clr_o), 32'd0);
        wait_edges(1);
        check("clr_CLR", 32'(clr_o), 32'd1);
        check("clr_S",   32'(s),     32'd1);
        wait_edges(1);
        check("clr_post_CLR", 32'(clr_o), 32'd0);
        check("clr_post_S",   32'(s),     32'd1);
        b_clr = 1'b0; b_mode = 1'b0;
        wait_edges(8);

        // MODE to alarm2, then idle until the timeout returns to the clock.
        b_mode = 1'b1;
        wait_edges(10);
        b_mode = 1'b0;
        wait_edges(26);
        check("timeout_pre_S", 32'(s), 32'd2);
        wait_edges(1);
        check("timeout_S",    32'(s),    32'd0);
        check("timeout_EDIT", 32'(edit), 32'd0);
        wait_edges(3);

        // ADV held 30 sampled cycles: INC at 7, 15, 18, ... 33.
        inc_at[0] = -1; inc_at[1] = -1; inc_at[2] = -1;
        inc_seen = 0;
        b_adv = 1'b1;
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (inc === 1'b1) begin
                if (inc_seen < 3) inc_at[inc_seen] = j;
                inc_seen++;
            end
            if (j == 29) b_adv = 1'b0;
        end
        check("adv_inc_count", 32'(inc_seen),  32'd8);
        check("adv_inc_first", 32'(inc_at[0]), 32'd7);
        check("adv_inc_2nd",   32'(inc_at[1]), 32'd15);
        check("adv_inc_3rd",   32'(inc_at[2]), 32'd18);
        wait_edges(5);

        // Short glitch is filtered out.
        inc_seen = 0;
        b_adv = 1'b1;
        wait_edges(3);
        b_adv = 1'b0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (inc === 1'b1) inc_seen++;
        end
        check("glitch_inc_count", 32'(inc_seen), 32'd0);

        // Reset mid-repeat, button still held afterwards.
        b_adv = 1'b1;
        wait_edges(20);
        rst = 1'b1;
        wait_edges(1);
        check("midrst_INC", 32'(inc), 32'd0);
        check("midrst_S",   32'(s),   32'd0);
        rst = 1'b0;
        wait_edges(7);
        check("postrst_pre_INC", 32'(inc), 32'd0);
        wait_edges(1);
        check("postrst_INC", 32'(inc), 32'd1);
        b_adv = 1'b0;
        wait_edges(10);

        // Random button activity, checked cycle by cycle against the model.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                b_mode = 1'b0; b_adv = 1'b0; b_clr = 1'b0;
                wait_edges($urandom_range(15, 35));
            end else begin
                b_mode = ($urandom_range(0, 3) == 0);
                b_adv  = ($urandom_range(0, 2) == 0);
                b_clr  = ($urandom_range(0, 5) == 0);
                wait_edges($urandom_range(1, 25));
            end
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                wait_edges($urandom_range(1, 2));
                rst = 1'b0;
            end
        end
        b_mode = 1'b0; b_adv = 1'b0; b_clr = 1'b0;
        wait_edges(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
